// File: rtl/ai_comp_pkg.sv
// ai_comp_pkg: compressed-word field positions, FSM encoding and helpers shared by the 4-sample compressor
package ai_comp_pkg;
    localparam int LAST_HI     = 55;
    localparam int NEXT_LO     = 17;
    localparam int ACT_LO      = 9;
    localparam int SEL_BIT     = 8;
    localparam int LAST_MEM_LO = 1;
    localparam int COMP_LAT    = 5;

    typedef enum logic [1:0] {IDLE, EVAL, CMP, EMIT} state_t;

    function automatic logic [7:0] q(input logic [7:0] x);
        return {x[7:1], 1'b0};
    endfunction

    function automatic logic [7:0] adiff(input logic [7:0] x, input logic [7:0] y);
        return x < y ? y - x : x - y;
    endfunction
endpackage

// File: rtl/ai_recon_4.sv
// ai_recon_4: decoder-exact reconstruction of four samples from anchors L, A and next value N
module ai_recon_4
    import ai_comp_pkg::*;
(
    input  logic [7:0] i_l,
    input  logic [7:0] i_a,
    input  logic [7:0] i_n,
    input  logic       i_sel,
    output logic [7:0] o_r1,
    output logic [7:0] o_r2,
    output logic [7:0] o_r3,
    output logic [7:0] o_r4
);
    logic       w_neg, w_neg2;
    logic [7:0] w_d, w_d2, w_r2;

    function automatic logic [7:0] step(input logic [7:0] b, input logic [7:0] d, input logic neg);
        return neg ? b - d : b + d;
    endfunction

    assign w_neg  = i_a < i_l;
    assign w_d    = adiff(i_a, i_l);
    assign w_neg2 = i_n < i_a;
    assign w_d2   = adiff(i_n, i_a);
    assign o_r1   = step(i_l, w_d >> 1, w_neg);
    assign w_r2   = step(step(o_r1, w_d >> 2, w_neg), w_d >> 3, w_neg);
    assign o_r2   = i_sel ? w_r2 : i_a;
    assign o_r3   = i_sel ? step(w_r2, w_d >> 4, w_neg) : step(i_a, w_d2 >> 4, w_neg2);
    assign o_r4   = i_sel ? i_a : step(i_a, w_d2 >> 3, w_neg2);
endmodule

// File: rtl/ai_compressor_4.sv
// ai_compressor_4: per frame, picks the lower-error interpolation mode and packs the compressed word
module ai_compressor_4
    import ai_comp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        compress,
    input  logic [63:0] data_in,
    input  logic        data_in_rdy,
    output logic        busy,
    output logic [63:0] data_out,
    output logic        data_out_rdy
);
    state_t          r_state, w_next;
    logic [63:0]     r_in, r_frame, w_word;
    logic            r_in_rdy, r_sel;
    logic [7:0]      r_prev, r_l, r_n, w_l, w_n;
    logic [11:0]     w_ext;
    logic [3:0][7:0] w_a, w_rec0, w_rec1, r_rec0, r_rec1;

    function automatic logic [9:0] err4(input logic [3:0][7:0] r, input logic [3:0][7:0] a);
        err4 = '0;
        for (int i = 0; i < 4; i++) err4 = err4 + {2'b0, adiff(r[i], a[i])};
    endfunction

    assign w_a   = r_frame[63:32];
    assign w_l   = q(r_prev);
    assign w_ext = {4'b0, w_a[2]} + (({4'b0, w_a[0]} - {4'b0, w_a[2]}) << 3);
    // signed extrapolation saturates: negative -> 0, above 255 -> 255
    assign w_n   = q(w_ext[11] ? 8'd0 : |w_ext[10:8] ? 8'hff : w_ext[7:0]);
    assign busy  = r_state != IDLE;

    ai_recon_4 u_rec0 (
        .i_l(w_l), .i_a(q(w_a[2])), .i_n(w_n), .i_sel(1'b0),
        .o_r1(w_rec0[3]), .o_r2(w_rec0[2]), .o_r3(w_rec0[1]), .o_r4(w_rec0[0])
    );

    ai_recon_4 u_rec1 (
        .i_l(w_l), .i_a(q(w_a[0])), .i_n(w_n), .i_sel(1'b1),
        .o_r1(w_rec1[3]), .o_r2(w_rec1[2]), .o_r3(w_rec1[1]), .o_r4(w_rec1[0])
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_in_rdy && compress) w_next = EVAL;
            EVAL:    w_next = CMP;
            CMP:     w_next = EMIT;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_word                       = '0;
        w_word[LAST_HI -: 32]        = r_frame[31:0];
        w_word[NEXT_LO +: 7]         = r_sel ? 7'd0 : r_n[7:1];
        w_word[ACT_LO +: 7]          = r_sel ? w_a[0][7:1] : w_a[2][7:1];
        w_word[SEL_BIT]              = r_sel;
        w_word[LAST_MEM_LO +: 7]     = r_l[7:1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_in         <= '0;
            r_in_rdy     <= 1'b0;
            r_frame      <= '0;
            r_rec0       <= '0;
            r_rec1       <= '0;
            r_l          <= '0;
            r_n          <= '0;
            r_sel        <= 1'b0;
            r_prev       <= '0;
            data_out     <= '0;
            data_out_rdy <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_in         <= data_in;
            r_in_rdy     <= data_in_rdy;
            data_out_rdy <= r_state == EMIT;
            if (r_state == IDLE && w_next == EVAL) r_frame <= r_in;
            if (r_state == EVAL) begin
                r_rec0 <= w_rec0;
                r_rec1 <= w_rec1;
                r_l    <= w_l;
                r_n    <= w_n;
            end
            if (r_state == CMP) r_sel <= err4(r_rec1, w_a) <= err4(r_rec0, w_a);
            if (init) r_prev <= '0;
            else if (r_state == CMP) r_prev <= w_a[0];
            if (r_state == EMIT) data_out <= w_word;
        end
    end
endmodule

// File: tb/tb_ai_compressor_4.sv
// tb_ai_compressor_4: randomized and directed checks of the compressor against an arithmetic reference model
module tb_ai_compressor_4;
    logic        clk = 1'b0;
    logic        rst, init, compress, data_in_rdy, busy, data_out_rdy;
    logic [63:0] data_in, data_out;
    int          total = 0;
    int          bad = 0;
    int          m_prev = 0;

    ai_compressor_4 dut (
        .clk(clk), .rst(rst), .init(init), .compress(compress),
        .data_in(data_in), .data_in_rdy(data_in_rdy), .busy(busy),
        .data_out(data_out), .data_out_rdy(data_out_rdy)
    );

    always #5 clk = ~clk;

    function automatic int qi(input int x);
        return x & 254;
    endfunction

    function automatic int iabs(input int x);
        return x < 0 ? -x : x;
    endfunction

    // reconstruct both modes with plain integer arithmetic and pick the smaller error sum
    function automatic logic [63:0] model(input int prev, input logic [63:0] f);
        int   a[4], r0[4], r1[4];
        int   l, s, d, n, e0, e1, an;
        logic sel;
        for (int i = 0; i < 4; i++) a[i] = int'(f[63-8*i -: 8]);
        l = qi(prev);
        an = qi(a[3]);
        s = an < l ? -1 : 1;
        d = iabs(an - l);
        r1[0] = (l + s * (d >> 1)) & 255;
        r1[1] = (r1[0] + s * ((d >> 2) + (d >> 3))) & 255;
        r1[2] = (r1[1] + s * (d >> 4)) & 255;
        r1[3] = an;
        an = qi(a[1]);
        s = an < l ? -1 : 1;
        d = iabs(an - l);
        r0[0] = (l + s * (d >> 1)) & 255;
        r0[1] = an;
        n = a[1] + 8 * (a[3] - a[1]);
        n = qi(n < 0 ? 0 : n > 255 ? 255 : n);
        s = n < an ? -1 : 1;
        d = iabs(n - an);
        r0[2] = (an + s * (d >> 4)) & 255;
        r0[3] = (an + s * (d >> 3)) & 255;
        e0 = 0;
        e1 = 0;
        for (int i = 0; i < 4; i++) begin
            e0 += iabs(r0[i] - a[i]);
            e1 += iabs(r1[i] - a[i]);
        end
        sel = e1 <= e0;
        return {8'h00, f[31:0], 24'h0} | 64'(l) |
               (sel ? (64'h100 | (64'(qi(a[3])) << 8)) : ((64'(n) << 16) | (64'(an) << 8)));
    endfunction

    function automatic logic [63:0] rnd_frame();
        logic [63:0] f;
        logic [7:0]  b, s;
        f = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) begin
            b = 8'($urandom);
            s = 8'($urandom_range(0, 40));
            f[63:32] = {b, 8'(b + s), 8'(b + 2 * s), 8'(b + 3 * s)};
        end
        return f;
    endfunction

    task automatic pulse_init();
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        m_prev = 0;
    endtask

    task automatic run_frame(input logic [63:0] f, output logic [63:0] got, output int lat, output logic extra);
        @(negedge clk);
        data_in = f;
        data_in_rdy = 1'b1;
        lat = 0;
        got = '0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            data_in_rdy = 1'b0;
            data_in = {$urandom, $urandom};
            if (data_out_rdy) begin
                lat = k;
                got = data_out;
            end
        end
        @(negedge clk);
        extra = data_out_rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (data_out !== 64'h0) begin bad++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        total++;
        if (data_out_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", data_out_rdy); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        m_prev = 0;
    endtask

    task automatic test_directed();
        logic [63:0] got, exp [4], fr [4];
        int          lat;
        logic        extra;
        fr[0] = 64'h08101820_01020304;  exp[0] = 64'h0001020304901000;
        fr[1] = 64'h0;                  exp[1] = 64'h0000000000000100;
        fr[2] = 64'h20202020_00000000;  exp[2] = 64'h0000000000002120;
        fr[3] = 64'h000000ff_00000000;  exp[3] = 64'h0000000000fe0000;
        for (int i = 0; i < 4; i++) begin
            if (i != 2) pulse_init();
            else begin
                run_frame(fr[0], got, lat, extra);
                m_prev = 32;
            end
            run_frame(fr[i], got, lat, extra);
            m_prev = int'(fr[i][39:32]);
            total++;
            if (got !== exp[i]) begin bad++; $display("FAIL directed%0d_word: got %h want %h", i, got, exp[i]); end
            total++;
            if (lat !== 5) begin bad++; $display("FAIL directed%0d_latency: got %0d want 5", i, lat); end
            total++;
            if (extra !== 1'b0) begin bad++; $display("FAIL directed%0d_rdy_width: rdy still %b want 0", i, extra); end
        end
    endtask

    task automatic test_random();
        logic [63:0] f, got, exp;
        int          lat;
        logic        extra;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0) pulse_init();
            f = rnd_frame();
            exp = model(m_prev, f);
            run_frame(f, got, lat, extra);
            m_prev = int'(f[39:32]);
            total++;
            if (got !== exp) begin bad++; $display("FAIL random%0d_word: got %h want %h", i, got, exp); end
            total++;
            if (lat !== 5) begin bad++; $display("FAIL random%0d_latency: got %0d want 5", i, lat); end
            total++;
            if (extra !== 1'b0) begin bad++; $display("FAIL random%0d_rdy_width: rdy still %b want 0", i, extra); end
        end
    endtask

    task automatic test_drop();
        logic [63:0] f1, got, exp;
        logic [5:1]  bz;
        int          outs;
        f1 = rnd_frame();
        exp = model(m_prev, f1);
        @(negedge clk);
        data_in = f1;
        data_in_rdy = 1'b1;
        outs = 0;
        bz = '0;
        got = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            data_in_rdy = k == 2;
            data_in = {$urandom, $urandom};
            if (k <= 5) bz[k] = busy;
            if (data_out_rdy) begin
                outs++;
                got = data_out;
            end
        end
        m_prev = int'(f1[39:32]);
        total++;
        if (outs !== 1) begin bad++; $display("FAIL drop_count: got %0d outputs want 1", outs); end
        total++;
        if (got !== exp) begin bad++; $display("FAIL drop_word: got %h want %h", got, exp); end
        total++;
        if (bz !== 5'b01110) begin bad++; $display("FAIL drop_busy: got %b want 01110", bz); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] f1, f2, e1, e2, g [2];
        int          at [2];
        int          outs;
        f1 = rnd_frame();
        f2 = rnd_frame();
        e1 = model(m_prev, f1);
        e2 = model(int'(f1[39:32]), f2);
        @(negedge clk);
        data_in = f1;
        data_in_rdy = 1'b1;
        outs = 0;
        g[0] = '0; g[1] = '0; at[0] = 0; at[1] = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            data_in_rdy = k == 4;
            data_in = k == 4 ? f2 : {$urandom, $urandom};
            if (data_out_rdy) begin
                if (outs < 2) begin
                    g[outs] = data_out;
                    at[outs] = k;
                end
                outs++;
            end
        end
        m_prev = int'(f2[39:32]);
        total++;
        if (outs !== 2) begin bad++; $display("FAIL b2b_count: got %0d outputs want 2", outs); end
        total++;
        if (g[0] !== e1) begin bad++; $display("FAIL b2b_word1: got %h want %h", g[0], e1); end
        total++;
        if (g[1] !== e2) begin bad++; $display("FAIL b2b_word2: got %h want %h", g[1], e2); end
        total++;
        if (at[0] !== 5 || at[1] !== 9) begin bad++; $display("FAIL b2b_timing: got %0d,%0d want 5,9", at[0], at[1]); end
    endtask

    task automatic test_mid_reset();
        logic [63:0] f, got, exp;
        int          lat, outs;
        logic        extra, bz;
        f = 64'h11223344_55667788 | 64'h00000080_00000000;
        run_frame(f, got, lat, extra);
        m_prev = int'(f[39:32]);
        @(negedge clk);
        data_in = rnd_frame();
        data_in_rdy = 1'b1;
        bz = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            data_in_rdy = 1'b0;
            if (k == 3) begin
                bz = busy;
                rst = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        m_prev = 0;
        outs = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (data_out_rdy) outs++;
        end
        total++;
        if (bz !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", bz); end
        total++;
        if (outs !== 0) begin bad++; $display("FAIL midrst_no_output: got %0d outputs want 0", outs); end
        total++;
        if (data_out !== 64'h0) begin bad++; $display("FAIL midrst_data_out: got %h want 0", data_out); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy_after: got %b want 0", busy); end
        f = rnd_frame() | 64'h80808080_00000000;
        exp = model(0, f);
        run_frame(f, got, lat, extra);
        m_prev = int'(f[39:32]);
        total++;
        if (got !== exp) begin bad++; $display("FAIL midrst_next_frame: got %h want %h", got, exp); end
    endtask

    task automatic test_compress_off();
        logic [63:0] f, got, exp;
        int          lat, outs;
        logic        extra, anybusy;
        compress = 1'b0;
        @(negedge clk);
        data_in = rnd_frame();
        data_in_rdy = 1'b1;
        outs = 0;
        anybusy = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            data_in_rdy = 1'b0;
            if (data_out_rdy) outs++;
            anybusy = anybusy | busy;
        end
        compress = 1'b1;
        total++;
        if (outs !== 0) begin bad++; $display("FAIL nocomp_output: got %0d outputs want 0", outs); end
        total++;
        if (anybusy !== 1'b0) begin bad++; $display("FAIL nocomp_busy: got %b want 0", anybusy); end
        f = rnd_frame();
        exp = model(m_prev, f);
        run_frame(f, got, lat, extra);
        m_prev = int'(f[39:32]);
        total++;
        if (got !== exp) begin bad++; $display("FAIL nocomp_prev_kept: got %h want %h", got, exp); end
    endtask

    task automatic test_init_collision();
        logic [63:0] f, got, exp;
        int          lat;
        logic        extra;
        f = rnd_frame() | 64'h00000080_00000000;
        exp = model(m_prev, f);
        @(negedge clk);
        data_in = f;
        data_in_rdy = 1'b1;
        got = '0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            data_in_rdy = 1'b0;
            init = k == 3;
            if (data_out_rdy) got = data_out;
        end
        m_prev = 0;
        total++;
        if (got !== exp) begin bad++; $display("FAIL initcol_word: got %h want %h", got, exp); end
        f = rnd_frame() | 64'h80808080_00000000;
        exp = model(0, f);
        run_frame(f, got, lat, extra);
        m_prev = int'(f[39:32]);
        total++;
        if (got !== exp) begin bad++; $display("FAIL initcol_prev_cleared: got %h want %h", got, exp); end
    endtask

    initial begin
        rst = 1'b1;
        init = 1'b0;
        compress = 1'b1;
        data_in = '0;
        data_in_rdy = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_drop();
        test_back_to_back();
        test_mid_reset();
        test_compress_off();
        test_init_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
